// File: rtl/irqctl_pkg.sv
// Shared definitions for the super-I/O interrupt controller.
package irqctl_pkg;

    localparam int unsigned NSRC          = 8;
    localparam int unsigned IDXW          = 3;
    localparam int unsigned AW            = 3;
    localparam int unsigned VEC_VALID_BIT = 7;

    // Peripheral-bus register map
    typedef enum logic [AW-1:0] {
        IRQ_STATUS = 3'd0,
        IRQ_MASK   = 3'd1,
        IRQ_MODE   = 3'd2,
        IRQ_POL    = 3'd3,
        IRQ_VEC0   = 3'd4,
        IRQ_RAW    = 3'd5,
        IRQ_ROUTE  = 3'd6,
        IRQ_VEC1   = 3'd7
    } irq_addr_e;

    // Vector register layout: valid flag on top, source index in the low bits.
    function automatic logic [NSRC-1:0] vec_pack(input logic valid, input logic [IDXW-1:0] idx);
        logic [NSRC-1:0] v;
        v                = '0;
        v[VEC_VALID_BIT] = valid;
        v[IDXW-1:0]      = idx;
        return v;
    endfunction

endpackage

// File: rtl/irq_prienc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prienc
    import irqctl_pkg::*;
(
    input  logic [NSRC-1:0] req,
    output logic            valid_c,
    output logic [IDXW-1:0] idx_c
);

    // Scan from the top down so the lowest index is the last one to land
    always_comb begin
        valid_c = |req;
        idx_c   = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/irqctl.sv
// Interrupt controller: synchronise, latch, mask, route and prioritise 8 sources onto irq0/irq1.
module irqctl
    import irqctl_pkg::*;
#(
    parameter logic [NSRC-1:0] MASK_RESET = 8'h00,
    parameter logic [NSRC-1:0] MODE_RESET = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   AD,
    input  logic [NSRC-1:0] DI,
    output logic [NSRC-1:0] DO,
    input  logic            rw,
    input  logic            cs,
    input  logic [NSRC-1:0] src,
    output logic            irq0,
    output logic            irq1
);

    logic [NSRC-1:0] s1, s2, act_prev, pend;
    logic [NSRC-1:0] mask_r, mode_r, pol_r, route_r;

    logic [NSRC-1:0] act, rise, pend_nxt;
    logic [NSRC-1:0] w1c, mode_chg, pol_chg;
    logic [NSRC-1:0] grp0, grp1;
    logic            we, wr_status, wr_mask, wr_mode, wr_pol, wr_route;
    logic            v0_c, v1_c;
    logic [IDXW-1:0] i0_c, i1_c;

    // Bus write decode and per-bit change masks
    always_comb begin
        we        = cs && !rw;
        wr_status = we && (AD == IRQ_STATUS);
        wr_mask   = we && (AD == IRQ_MASK);
        wr_mode   = we && (AD == IRQ_MODE);
        wr_pol    = we && (AD == IRQ_POL);
        wr_route  = we && (AD == IRQ_ROUTE);
        w1c       = wr_status ? DI : '0;
        mode_chg  = wr_mode ? (DI ^ mode_r) : '0;
        pol_chg   = wr_pol ? (DI ^ pol_r) : '0;
        act       = s2 ^ pol_r;
        rise      = act & ~act_prev;
    end

    // Next pending: config changes clear; level follows act; edge sets over W1C, else holds
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (mode_chg[i] || pol_chg[i]) begin
                pend_nxt[i] = 1'b0;
            end else if (!mode_r[i]) begin
                pend_nxt[i] = act[i];
            end else if (rise[i]) begin
                pend_nxt[i] = 1'b1;
            end else if (w1c[i]) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    // Unmasked requests split by routing group
    always_comb begin
        grp0 = pend & mask_r & ~route_r;
        grp1 = pend & mask_r & route_r;
    end

    irq_prienc u_prienc0 (
        .req     (grp0),
        .valid_c (v0_c),
        .idx_c   (i0_c)
    );

    irq_prienc u_prienc1 (
        .req     (grp1),
        .valid_c (v1_c),
        .idx_c   (i1_c)
    );

    // Synchroniser, pending latch, config registers and registered IRQ outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            act_prev <= '0;
            pend     <= '0;
            mask_r   <= MASK_RESET;
            mode_r   <= MODE_RESET;
            pol_r    <= '0;
            route_r  <= '0;
            irq0     <= 1'b0;
            irq1     <= 1'b0;
        end else begin
            s1       <= src;
            s2       <= s1;
            // Re-seed history with the new polarity so a POL write is not seen as an edge
            act_prev <= wr_pol ? (s2 ^ DI) : act;
            pend     <= pend_nxt;
            if (wr_mask)  mask_r  <= DI;
            if (wr_mode)  mode_r  <= DI;
            if (wr_pol)   pol_r   <= DI;
            if (wr_route) route_r <= DI;
            irq0     <= |grp0;
            irq1     <= |grp1;
        end
    end

    // Read mux, combinational from AD; chip-select gating happens at the top level
    always_comb begin
        DO = '0;
        case (irq_addr_e'(AD))
            IRQ_STATUS: DO = pend & mask_r;
            IRQ_MASK:   DO = mask_r;
            IRQ_MODE:   DO = mode_r;
            IRQ_POL:    DO = pol_r;
            IRQ_VEC0:   DO = vec_pack(v0_c, i0_c);
            IRQ_RAW:    DO = s2;
            IRQ_ROUTE:  DO = route_r;
            IRQ_VEC1:   DO = vec_pack(v1_c, i1_c);
            default:    DO = '0;
        endcase
    end

endmodule
